// File: rtl/ila_check_sequencer.sv
// Single-shot sequencer for ILA instruction-level refinement checks: issues START, counts
// cycles, pulses IEND and second-end, and holds nondeterministic function results.
module ila_check_sequencer #(
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned MAX_CNT = 6,
    parameter int unsigned FUNC_N  = 4,
    parameter int unsigned FUNC_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_i,
    input  logic [CNT_W-1:0]         end_cycle_i,
    input  logic                     decode_i,
    input  logic                     valid_i,
    input  logic [FUNC_N*FUNC_W-1:0] func_init_i,
    input  logic [FUNC_N*FUNC_W-1:0] func_wire_i,
    output logic                     start_o,
    output logic                     started_o,
    output logic [CNT_W-1:0]         cycle_cnt_o,
    output logic                     iend_o,
    output logic                     second_end_o,
    output logic                     ended_o,
    output logic                     abort_o,
    output logic                     reseted_o,
    output logic [FUNC_N*FUNC_W-1:0] func_reg_o,
    output logic [FUNC_N-1:0]        func_match_o
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_CNT);

    typedef enum logic [2:0] {StIdle, StStart, StRun, StDone, StAbort} state_e;

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           end_q;
    logic [CNT_W-1:0]           cnt_q;
    logic                       started_q;
    logic                       ended_q;
    logic                       second_end_q;
    logic                       reseted_q;
    logic [FUNC_N*FUNC_W-1:0]   func_q;
    logic                       iend;

    assign start_o = (state_q == StStart);
    assign iend    = (state_q == StRun) && (cnt_q == end_q) && reseted_q && !ended_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (issue_i) state_d = StStart;
            StStart: begin
                if (!decode_i || !valid_i || (end_q == '0) || (end_q > MaxCnt)) begin
                    state_d = StAbort;
                end else begin
                    state_d = StRun;
                end
            end
            StRun:   if (iend) state_d = StDone;
            StDone:  state_d = StDone;
            StAbort: state_d = StAbort;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            end_q        <= '0;
            cnt_q        <= '0;
            started_q    <= 1'b0;
            ended_q      <= 1'b0;
            second_end_q <= 1'b0;
            reseted_q    <= 1'b1;
            func_q       <= func_init_i;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && issue_i) end_q <= end_cycle_i;
            // Saturating count; stops advancing once abort leaves started clear.
            if ((start_o || started_q) && (cnt_q < MaxCnt)) cnt_q <= cnt_q + CNT_W'(1);
            if (state_q == StStart && state_d == StRun) started_q <= 1'b1;
            if (iend) ended_q <= 1'b1;
            second_end_q <= iend;
        end
    end

    always_comb begin
        func_match_o = '1;
        for (int k = 0; k < int'(FUNC_N); k++) begin
            func_match_o[k] = !start_o ||
                              (func_q[k*FUNC_W +: FUNC_W] == func_wire_i[k*FUNC_W +: FUNC_W]);
        end
    end

    assign started_o    = started_q;
    assign cycle_cnt_o  = cnt_q;
    assign iend_o       = iend;
    assign second_end_o = second_end_q;
    assign ended_o      = ended_q;
    assign abort_o      = (state_q == StAbort);
    assign reseted_o    = reseted_q;
    assign func_reg_o   = func_q;

endmodule

// File: tb/tb_ila_check_sequencer.sv
// Directed bench for ila_check_sequencer: a per-cycle vector table plus hand-written
// sequences for function-result matching and mid-check reset.
module tb_ila_check_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_i = 1'b0;
    logic [3:0]  end_cycle_i = '0;
    logic        decode_i = 1'b1;
    logic        valid_i = 1'b1;
    logic [31:0] func_init_i = '0;
    logic [31:0] func_wire_i = '0;
    logic        start_o, started_o, iend_o, second_end_o, ended_o, abort_o, reseted_o;
    logic [3:0]  cycle_cnt_o;
    logic [31:0] func_reg_o;
    logic [3:0]  func_match_o;

    int n_cmp = 0;
    int n_err = 0;

    ila_check_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .issue_i     (issue_i),
        .end_cycle_i (end_cycle_i),
        .decode_i    (decode_i),
        .valid_i     (valid_i),
        .func_init_i (func_init_i),
        .func_wire_i (func_wire_i),
        .start_o     (start_o),
        .started_o   (started_o),
        .cycle_cnt_o (cycle_cnt_o),
        .iend_o      (iend_o),
        .second_end_o(second_end_o),
        .ended_o     (ended_o),
        .abort_o     (abort_o),
        .reseted_o   (reseted_o),
        .func_reg_o  (func_reg_o),
        .func_match_o(func_match_o)
    );

    always #5 clk = ~clk;

    // One row per cycle: inputs applied after the falling edge, outputs checked before the
    // next rising edge. Expected cnt of 15 means the count is not checked on that row.
    typedef struct {
        logic       rst, issue;
        logic [3:0] endc;
        logic       dec, val, chk;
        logic       st, sd;
        logic [3:0] cnt;
        logic       ie, se, en, ab;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(bit r, bit is, int ec, bit d, bit va, bit c,
                               bit st, bit sd, int cnt, bit ie, bit se, bit en, bit ab);
        vec_t x;
        x.rst = r; x.issue = is; x.endc = 4'(ec); x.dec = d; x.val = va; x.chk = c;
        x.st = st; x.sd = sd; x.cnt = 4'(cnt); x.ie = ie; x.se = se; x.en = en; x.ab = ab;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        issue_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        //                 rst is ec d v chk  st sd cnt ie se en ab
        // Nominal, end cycle 1; issue held high through DONE must not restart.
        tbl.push_back(v(1, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 1, 1, 1,   0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 1, 1, 1,   1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 1, 1, 1,   0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 1, 1, 1,   0, 1, 2, 0, 1, 1, 0));
        tbl.push_back(v(0, 1, 1, 1, 1, 1,   0, 1, 3, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 1, 1, 1, 1,   0, 1, 4, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 1, 1, 1, 1,   0, 1, 5, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 1, 1, 1, 1,   0, 1, 6, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 1, 1, 1, 1,   0, 1, 6, 0, 0, 1, 0));
        // End cycle 4 latched; end_cycle_i moved to 2 afterwards must be ignored.
        tbl.push_back(v(1, 0, 0, 1, 1, 1,   0, 1, 6, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 4, 1, 1, 1,   0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 2, 1, 1, 1,   1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 2, 1, 1, 1,   0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 2, 1, 1, 1,   0, 1, 2, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 2, 1, 1, 1,   0, 1, 3, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 2, 1, 1, 1,   0, 1, 4, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 2, 1, 1, 1,   0, 1, 5, 0, 1, 1, 0));
        tbl.push_back(v(0, 0, 2, 1, 1, 1,   0, 1, 6, 0, 0, 1, 0));
        // Abort: decode low; issue in ABORT ignored.
        tbl.push_back(v(1, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 3, 0, 1, 1,   0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 3, 0, 1, 1,   1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 3, 1, 1, 1,   0, 0, 15, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 3, 1, 1, 1,   0, 0, 15, 0, 0, 0, 1));
        // Abort: end cycle 0.
        tbl.push_back(v(1, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 1, 1,   0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 1, 1,   1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 1, 1,   0, 0, 15, 0, 0, 0, 1));
        // Abort: end cycle 7 (> MAX_CNT).
        tbl.push_back(v(1, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 7, 1, 1, 1,   0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 7, 1, 1, 1,   1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 7, 1, 1, 1,   0, 0, 15, 0, 0, 0, 1));
        // Abort: valid low.
        tbl.push_back(v(1, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 2, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 2, 1, 0, 1,   1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 2, 1, 1, 1,   0, 0, 15, 0, 0, 0, 1));
        // End cycle at MAX_CNT: IEND coincides with saturation.
        tbl.push_back(v(1, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 6, 1, 1, 1,   0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 6, 1, 1, 1,   1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 6, 1, 1, 1,   0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 6, 1, 1, 1,   0, 1, 2, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 6, 1, 1, 1,   0, 1, 3, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 6, 1, 1, 1,   0, 1, 4, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 6, 1, 1, 1,   0, 1, 5, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 6, 1, 1, 1,   0, 1, 6, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 6, 1, 1, 1,   0, 1, 6, 0, 1, 1, 0));
        // Reset and issue together: reset wins, no START follows.
        tbl.push_back(v(1, 1, 2, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 2, 1, 1, 1,   0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 2, 1, 1, 1,   0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst         = tbl[i].rst;
            issue_i     = tbl[i].issue;
            end_cycle_i = tbl[i].endc;
            decode_i    = tbl[i].dec;
            valid_i     = tbl[i].val;
            #1;
            if (tbl[i].chk) begin
                check($sformatf("row%0d flags{st,sd,ie,se,en,ab}", i),
                      32'({start_o, started_o, iend_o, second_end_o, ended_o, abort_o}),
                      32'({tbl[i].st, tbl[i].sd, tbl[i].ie, tbl[i].se, tbl[i].en, tbl[i].ab}));
                if (tbl[i].cnt != 4'd15)
                    check($sformatf("row%0d cycle_cnt", i), 32'(cycle_cnt_o), 32'(tbl[i].cnt));
                check($sformatf("row%0d reseted", i), 32'(reseted_o), 32'd1);
            end
        end

        // Function results: held from reset, mismatch on slot 2 visible only in START.
        func_init_i = 32'h4433_2211;
        func_wire_i = 32'h4400_2211;
        end_cycle_i = 4'd1;
        decode_i = 1'b1;
        valid_i = 1'b1;
        do_reset();
        func_init_i = 32'hdead_beef;
        issue_i = 1'b1;
        #1;
        check("func idle match", 32'(func_match_o), 32'hf);
        check("func idle reg", func_reg_o, 32'h4433_2211);
        @(negedge clk);
        issue_i = 1'b0;
        #1;
        check("func start flag", 32'(start_o), 32'd1);
        check("func start match", 32'(func_match_o), 32'hb);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("func post%0d match", c), 32'(func_match_o), 32'hf);
            check($sformatf("func post%0d reg", c), func_reg_o, 32'h4433_2211);
        end

        // Mid-check reset at count 2 with end cycle 4, then a fresh check.
        func_init_i = '0;
        func_wire_i = '0;
        do_reset();
        issue_i = 1'b1;
        end_cycle_i = 4'd4;
        @(negedge clk);
        issue_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mid cnt before rst", 32'(cycle_cnt_o), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid after rst flags", 32'({start_o, started_o, iend_o, second_end_o, ended_o,
              abort_o}), 32'd0);
        check("mid after rst cnt", 32'(cycle_cnt_o), 32'd0);
        @(negedge clk);
        #1;
        check("mid idle no iend", 32'({start_o, iend_o, started_o}), 32'd0);
        issue_i = 1'b1;
        end_cycle_i = 4'd1;
        @(negedge clk);
        issue_i = 1'b0;
        #1;
        check("mid fresh start", 32'(start_o), 32'd1);
        @(negedge clk);
        #1;
        check("mid fresh iend", 32'({iend_o, started_o}), 32'b11);
        check("mid fresh cnt", 32'(cycle_cnt_o), 32'd1);
        @(negedge clk);
        #1;
        check("mid fresh second_end", 32'({second_end_o, ended_o, iend_o}), 32'b110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ila_check_sequencer.md
Name: ila_check_sequencer

Overview:
- Single-shot controller for instruction-level refinement checks in the vpipe verification harnesses.
- Takes the issue request and sequences the check: one-cycle START, cycle counting, end-of-instruction (IEND) and second-end pulses, and abort on an inapplicable instruction.
- Owns the held registers for nondeterministic function results and drives their per-function match flags.
- Sits between the ILA instruction model and the implementation under check, and drives their assume/assert qualifiers.

Parameters:
- CNT_W, 4, width of the cycle counter and of end_cycle_i.
- MAX_CNT, 6, saturation value of the cycle counter; legal end cycles are 1..MAX_CNT.
- FUNC_N, 4, number of nondeterministic function result slots.
- FUNC_W, 8, width of each function result.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- issue_i  in  1  request to start a check.
- end_cycle_i  in  CNT_W  cycle on which the instruction ends; sampled when the issue is accepted.
- decode_i  in  1  ILA decode flag for the instruction under check.
- valid_i  in  1  ILA valid flag.
- func_init_i  in  FUNC_N*FUNC_W  reset values for the function registers; slot k is bits [k*FUNC_W +: FUNC_W].
- func_wire_i  in  FUNC_N*FUNC_W  live function outputs from the ILA model.
- start_o  out  1  one-cycle pulse: ILA applies the instruction; variable-map assumes are active.
- started_o  out  1  sticky: check is in progress or has completed.
- cycle_cnt_o  out  CNT_W  cycles since start_o.
- iend_o  out  1  one-cycle pulse: variable-map asserts are active.
- second_end_o  out  1  one-cycle pulse one cycle after iend_o.
- ended_o  out  1  sticky after iend_o.
- abort_o  out  1  sticky: check abandoned.
- reseted_o  out  1  sticky: at least one reset has occurred.
- func_reg_o  out  FUNC_N*FUNC_W  held function results.
- func_match_o  out  FUNC_N  per-slot equality qualifier.

Behaviour:
- States: IDLE, START, RUN, DONE, ABORT. Reset enters IDLE from any state, including mid-check.
- Reset values:
  - start_o, started_o, iend_o, second_end_o, ended_o, abort_o = 0.
  - cycle_cnt_o = 0.
  - reseted_o = 1.
  - func_reg_o = func_init_i.
  - Internal end-cycle register = 0.
- reseted_o is never cleared once set. Before the first reset it is X and is not checked.
- IDLE:
  - issue_i=1: latch end_cycle_i, go to START.
  - Otherwise remain in IDLE.
- START (start_o=1 for exactly this cycle):
  - If decode_i=0, valid_i=0, latched end cycle = 0, or latched end cycle > MAX_CNT: go to ABORT.
  - Otherwise go to RUN; started_o=1 and cycle_cnt_o=1 on the next cycle.
- Counter:
  - Increments by 1 each cycle while in START or started, provided cycle_cnt_o < MAX_CNT.
  - Saturates at MAX_CNT; never wraps.
  - Holds in IDLE and ABORT.
- RUN:
  - iend_o = (cycle_cnt_o == latched end cycle) && reseted_o && !ended_o. This is combinational.
  - On iend_o: ended_o sets on the next cycle and the state goes to DONE.
- DONE:
  - second_end_o=1 on the first DONE cycle only, then 0.
  - The state is terminal until reset.
- ABORT: terminal until reset; abort_o=1.
- issue_i is ignored outside IDLE. There is no re-arm; a new check requires rst.
- Function registers: loaded from func_init_i on rst; otherwise they hold their value permanently.
- func_match_o[k] = !start_o || (func_reg_o slot k == func_wire_i slot k). This is combinational.
- Latency: issue_i to start_o is 1 cycle. start_o to iend_o is exactly the latched end cycle count, in cycles.
- Simultaneous rst and issue_i: rst wins, and the state is IDLE on the next cycle.

Test Plan:
1. Nominal check:
   - Stimulus: rst for 1 cycle; issue_i=1 with end_cycle_i=1, decode_i=valid_i=1.
   - Required response: start_o at cycle 1; iend_o at cycle 2 with cycle_cnt_o=1; second_end_o at cycle 3; ended_o=1 from cycle 3; counter saturates at 6.
2. Longer end cycle:
   - Stimulus: end_cycle_i=4, with end_cycle_i changed to 2 one cycle after issue.
   - Required response: iend_o at cycle_cnt_o=4 only; no pulse at 2.
3. Abort conditions:
   - Stimulus: start with decode_i=0; separately with end_cycle_i=0; separately with end_cycle_i=7.
   - Required response: abort_o=1 the next cycle; iend_o and started_o never assert.
4. Function results:
   - Stimulus: func_init_i slots {0x11,0x22,0x33,0x44}; func_wire_i = {0x11,0x22,0x00,0x44} during start.
   - Required response: func_match_o=4'b1011 in the start cycle; all ones in other cycles; func_reg_o unchanged throughout.
5. Mid-check reset:
   - Stimulus: rst while cycle_cnt_o=2 in RUN with end cycle 4.
   - Required response: all outputs return to reset values; no iend_o; a fresh issue runs normally.
6. Re-issue:
   - Stimulus: issue_i held high through DONE.
   - Required response: no second start_o and no further iend_o.
